// File: rtl/clk_div_pkg.sv
// Shared helpers for the programmable clock divider.
//    div_clamp       - force a divisor up to the minimum legal value
//    div_decode_pow2 - turn exponent k into 2^k, with k limited to width-1
//    div_high_len    - high-phase length ceil(n/2) for a divisor n
package clk_div_pkg;

   localparam int unsigned DIV_MIN = 2;

   function automatic int unsigned div_clamp(input int unsigned v);
      return (v < DIV_MIN) ? DIV_MIN : v;
   endfunction

   function automatic int unsigned div_decode_pow2(input int unsigned k,
                                                   input int unsigned w);
      int unsigned k_lim;
      k_lim = (k > w - 1) ? w - 1 : k;
      return 32'd1 << k_lim;
   endfunction

   function automatic int unsigned div_high_len(input int unsigned n);
      return n - (n >> 1);
   endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Divisor configuration for clk_div_prog.
// Decodes and clamps a loaded divisor into a pending register, then swaps
// it into the active divisor only on a period-wrap edge so no phase is
// shortened or stretched.
//    clk, rst_n - clock, async active-low reset
//    div_load   - strobe: capture div_in/pow2 as pending divisor
//    div_in     - divisor value, or exponent when pow2=1
//    pow2       - interpret div_in as exponent
//    wrap       - counter wraps on this edge (enabled, cnt == N-1)
//    div_cur    - active divisor
//    div_pend   - a pending divisor awaits the next wrap
module clk_div_cfg
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_in,
   input  logic             pow2,
   input  logic             wrap,
   output logic [DIV_W-1:0] div_cur,
   output logic             div_pend
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(div_clamp(unsigned'(DEF_DIV)));

   logic [31:0]      dec_val;
   logic [DIV_W-1:0] load_val;
   logic [DIV_W-1:0] pend_val;

   always_comb begin
      dec_val  = pow2 ? div_decode_pow2(32'(div_in), unsigned'(DIV_W)) : 32'(div_in);
      load_val = DIV_W'(div_clamp(dec_val));
   end

   // The swap uses the pending state from before this edge; a load on the
   // same edge re-arms pending and is applied at the following wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cur  <= DIV_RST;
         pend_val <= DIV_RST;
         div_pend <= 1'b0;
      end else begin
         if (wrap && div_pend) begin
            div_cur  <= pend_val;
            div_pend <= 1'b0;
         end
         if (div_load) begin
            pend_val <= load_val;
            div_pend <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: registered divided level plus one-cycle
// rise/fall enable pulses, all synchronous to clk.
//    clk, rst_n - system clock, async active-low reset
//    en         - count enable; low freezes counter/level, clears pulses
//    div_load   - strobe: load new divisor (applied at next period wrap)
//    div_in     - divisor value, or exponent when pow2=1
//    pow2       - divisor = 2^div_in (exponent limited to DIV_W-1)
//    clk_out    - divided level, high for ceil(N/2) cycles
//    tick_rise  - one-cycle pulse when clk_out rises
//    tick_fall  - one-cycle pulse when clk_out falls
//    div_cur    - active divisor
//    div_pend   - new divisor waiting for period boundary
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int DIV_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             div_load,
   input  logic [DIV_W-1:0] div_in,
   input  logic             pow2,
   output logic             clk_out,
   output logic             tick_rise,
   output logic             tick_fall,
   output logic [DIV_W-1:0] div_cur,
   output logic             div_pend
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(div_clamp(unsigned'(DEF_DIV)));

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W-1:0] high_len;
   logic             wrap;

   clk_div_cfg #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
   ) u_cfg (
      .clk      (clk),
      .rst_n    (rst_n),
      .div_load (div_load),
      .div_in   (div_in),
      .pow2     (pow2),
      .wrap     (wrap),
      .div_cur  (div_cur),
      .div_pend (div_pend)
   );

   // On a wrap the next count is 0, which is always in the high phase, so
   // using the pre-swap divisor for high_len is safe on that edge.
   always_comb begin
      high_len = DIV_W'(div_high_len(32'(div_cur)));
      wrap     = en && (cnt == div_cur - DIV_W'(1));
      cnt_nxt  = wrap ? '0 : cnt + DIV_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= DIV_RST - DIV_W'(1);
         clk_out   <= 1'b0;
         tick_rise <= 1'b0;
         tick_fall <= 1'b0;
      end else if (en) begin
         cnt       <= cnt_nxt;
         clk_out   <= (cnt_nxt < high_len);
         tick_rise <= (cnt_nxt == '0);
         tick_fall <= (cnt_nxt == high_len);
      end else begin
         tick_rise <= 1'b0;
         tick_fall <= 1'b0;
      end
   end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Programmable, parametrised clock divider producing a registered divided-clock level plus single-cycle rising/falling-edge enable pulses, all synchronous to `clk`. Divisor is any integer 2..2^DIV_W−1 or a power of two 2^k, reloadable at runtime with glitch-free switchover at period boundaries. Sits beside the system clock root; downstream logic uses `tick_rise`/`tick_fall` as clock enables rather than clocking on `clk_out`.

## Interface
- `DIV_W`, 8, divisor width in bits; legal range 2..16
- `DEF_DIV`, 2, divisor after reset; clamped to ≥2
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  count enable; 0 freezes counter and outputs, pulses forced 0
- `div_load`  in  1  one-cycle strobe: capture `div_in`/`pow2` as pending divisor
- `div_in`  in  DIV_W  divisor value, or exponent k when `pow2`=1
- `pow2`  in  1  1: divisor = 2^k with k = `div_in`, k clamped to DIV_W−1
- `clk_out`  out  1  divided level, registered
- `tick_rise`  out  1  high for one `clk` cycle when `clk_out` goes 0→1
- `tick_fall`  out  1  high for one `clk` cycle when `clk_out` goes 1→0
- `div_cur`  out  DIV_W  effective divisor in use (after clamp)
- `div_pend`  out  1  pending divisor waiting for period boundary

## Operation
- Effective divisor N = max(decoded value, 2); decode: `pow2`=0 → `div_in`; `pow2`=1 → 1<<min(`div_in`, DIV_W−1).
- High time H = N − (N>>1) (ceil(N/2)); low time N>>1. Even N → 50 % duty; odd N → one extra high cycle.
- Counter `cnt` in [0, N−1]. Each edge with `en`=1: wrap = (`cnt` == N−1); `cnt` ← wrap ? 0 : `cnt`+1.
- `clk_out` ← (next `cnt` < H); `tick_rise` ← (next `cnt` == 0); `tick_fall` ← (next `cnt` == H).
- `div_load`=1: clamped decoded value → pending register, `div_pend` ← 1. Load accepted regardless of `en`.
- On a wrap edge with `div_pend`=1 (pending set before that edge): `div_cur` ← pending, `div_pend` ← 0, new period starts with new N.
- `div_load` on the same edge as a wrap: captured to pending, applied at the following wrap (not this one).
- Second `div_load` while pending: overwrites pending value; only the latest is applied.
- Reset values: `cnt` = clamp(DEF_DIV)−1, `div_cur` = clamp(DEF_DIV), `div_pend` = 0, `clk_out` = 0, `tick_rise` = 0, `tick_fall` = 0.

## Timing
- All outputs registered; no combinational path input→output.
- First enabled edge after reset wraps: `clk_out`=1 and `tick_rise`=1 in the next cycle.
- N=4: `cnt` 0,1,2,3,0 → `clk_out` 1,1,0,0,1; `tick_rise` 1,0,0,0,1; `tick_fall` 0,0,1,0,0.
- N=3: `clk_out` 1,1,0 repeating; `tick_fall` at `cnt`=2.
- Divisor change: latency from `div_load` to new period = remaining cycles of current period (≥1); no runt or stretched high/low phase.
- `en` deassert mid-period: state holds; resume continues the same period exactly where it stopped.
- `rst_n` low mid-operation: all state to reset values immediately (async); release is synchronous-safe via standard reset synchroniser outside this block.

## Structure
- Package `clk_div_pkg`: functions `div_clamp`, `div_decode_pow2`, `div_high_len`; localparam `DIV_MIN = 2`.
- Sub-module `clk_div_cfg`: decode/clamp, pending register, `div_pend`, swap at wrap; `clk_div_prog` holds counter and output registers.

## Test plan
- Reset, `en`=1, DEF_DIV=4 → `clk_out` 1100 repeating, `tick_rise` every 4 cycles, first one cycle after first edge.
- Load `div_in`=5, `pow2`=0 mid-period of N=4 → current period completes unchanged, then 11100 repeating, `div_pend` 1→0 at wrap.
- Load `pow2`=1, `div_in`=3 → N=8, `clk_out` 4 high / 4 low; `div_in`=12 with DIV_W=8 → N=128.
- Load `div_in`=0 and 1 → `div_cur`=2, `clk_out` toggles every cycle.
- `div_load` on wrap edge, then second load before next wrap → only second value applied, at next wrap.
- `en`=0 for 3 cycles mid-period, and `rst_n` pulse mid-period → hold exactly; reset returns all outputs to 0, `div_cur`=DEF_DIV.
